// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the decode-stage back end (id_stage_fwd, id_regfile).
//   - Default data width and register count.
//   - Bit positions of the control bits this stage interprets.
//   - Bubble control constant (all zero: no register write, no memory access).
//   - Operand source selector used by the forwarding muxes.
// -----------------------------------------------------------------------------
package id_pkg;

    localparam int XLEN_DEF        = 32;
    localparam int NREG_DEF        = 32;
    localparam int CW_DEF          = 13;

    // Control bundle bit positions
    localparam int RWEN_BIT_DEF    = 9;   // instruction writes a register
    localparam int MEMRD_BIT_DEF   = 1;   // instruction is a load
    localparam int RBVALID_BIT_DEF = 0;   // rB is a real source operand

    // Control word of an inserted bubble or killed entry
    localparam logic [CW_DEF-1:0] CTRL_BUBBLE = '0;

    // Where an operand comes from, in priority order
    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,   // source register 0
        FWD_EX   = 2'd1,   // ALU result of the ID/EX entry
        FWD_MEM  = 2'd2,   // MEM-stage result
        FWD_RF   = 2'd3    // register file (includes WB write-through)
    } fwd_src_e;

endpackage

// File: rtl/id_regfile.sv
// -----------------------------------------------------------------------------
// id_regfile
// NREG x XLEN register file, asynchronous active-low reset, one write port,
// two combinational read ports. A read of the index being written in the same
// cycle returns the write data. Register 0 reads as zero and ignores writes.
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   we, waddr, wdata    write port (WB stage)
//   raddr_a, rdata_a    read port A
//   raddr_b, rdata_b    read port B
// -----------------------------------------------------------------------------
module id_regfile
    import id_pkg::*;
#(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] mem_reg [NREG];

    // Every register is cleared on reset, so this is a flop array rather
    // than a RAM. Writes to register 0 are dropped here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0)                ? '0    :
                     (we && (waddr == raddr_a))     ? wdata :
                                                      mem_reg[raddr_a];

    assign rdata_b = (raddr_b == '0)                ? '0    :
                     (we && (waddr == raddr_b))     ? wdata :
                                                      mem_reg[raddr_b];

endmodule

// File: rtl/id_stage_fwd.sv
// -----------------------------------------------------------------------------
// id_stage_fwd
// Decode-stage back end: register file, operand forwarding, RAW hazard
// detection and the ID/EX pipeline register.
//
// Build option: macro ID_FWD_EN
//   defined   - operands forwarded from EX, MEM and WB; only load-use stalls.
//   undefined - only WB write-through; any in-flight producer (ID/EX entry or
//               MEM) of a used source stalls until it has reached WB.
//
// Ports
//   clk, rst_n                  clock / asynchronous active-low reset
//   in_valid, in_ready          ID handshake (in_ready = accepted this cycle)
//   pc_in, imm_in, ctrl_in,
//   alu_op_in                   decoded instruction fields
//   ra_idx, rb_idx, rw_idx      source / destination register indices
//   ex_alu_result               ALU result of the current ID/EX entry
//   mem_we, mem_sel, mem_data   MEM-stage destination and result
//   wb_we, wb_sel, wb_data      register-file write port
//   out_ready, flush            EX back-pressure / kill ID/EX entry
//   out_valid, out_pc, out_imm,
//   out_ra_v, out_rb_v,
//   out_ctrl, out_alu_op, out_rw  ID/EX register contents
//   hazard_stall                stall (bubble insertion) this cycle
// -----------------------------------------------------------------------------
module id_stage_fwd
    import id_pkg::*;
#(
    parameter int  XLEN        = XLEN_DEF,
    parameter int  NREG        = NREG_DEF,
    parameter int  CW          = CW_DEF,
    parameter int  RWEN_BIT    = RWEN_BIT_DEF,
    parameter int  MEMRD_BIT   = MEMRD_BIT_DEF,
    parameter int  RBVALID_BIT = RBVALID_BIT_DEF,
    localparam int AW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [CW-1:0]   ctrl_in,
    input  logic [3:0]      alu_op_in,
    input  logic [AW-1:0]   ra_idx,
    input  logic [AW-1:0]   rb_idx,
    input  logic [AW-1:0]   rw_idx,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_sel,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_sel,
    input  logic [XLEN-1:0] wb_data,
    input  logic            out_ready,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_ra_v,
    output logic [XLEN-1:0] out_rb_v,
    output logic [CW-1:0]   out_ctrl,
    output logic [3:0]      out_alu_op,
    output logic [AW-1:0]   out_rw,
    output logic            hazard_stall
);

    // ID/EX register
    logic            out_valid_reg;
    logic [XLEN-1:0] out_pc_reg;
    logic [XLEN-1:0] out_imm_reg;
    logic [XLEN-1:0] out_ra_v_reg;
    logic [XLEN-1:0] out_rb_v_reg;
    logic [CW-1:0]   out_ctrl_reg;
    logic [3:0]      out_alu_op_reg;
    logic [AW-1:0]   out_rw_reg;

    // Per-source operand path: index 0 = rA, index 1 = rB
    logic [1:0][AW-1:0]   src_idx;
    logic [1:0][XLEN-1:0] rf_rdata;
    logic [1:0][XLEN-1:0] opnd;
    logic [1:0]           src_nz;
    logic [1:0]           ex_hit;    // ID/EX entry (any writer, loads included) targets source
    logic [1:0]           mem_hit;   // MEM stage targets source

    logic ex_writes;
    logic ex_is_load;
    logic rb_used;
    logic advance;
    logic stall;

    assign src_idx[0] = ra_idx;
    assign src_idx[1] = rb_idx;

    assign ex_writes  = out_valid_reg && out_ctrl_reg[RWEN_BIT];
    assign ex_is_load = out_ctrl_reg[MEMRD_BIT];
    assign rb_used    = ctrl_in[RBVALID_BIT];

    id_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_we),
        .waddr   (wb_sel),
        .wdata   (wb_data),
        .raddr_a (ra_idx),
        .raddr_b (rb_idx),
        .rdata_a (rf_rdata[0]),
        .rdata_b (rf_rdata[1])
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_nz[gi]  = (src_idx[gi] != '0);
            assign ex_hit[gi]  = src_nz[gi] && ex_writes && (out_rw_reg == src_idx[gi]);
            assign mem_hit[gi] = src_nz[gi] && mem_we && (mem_sel == src_idx[gi]);
`ifdef ID_FWD_EN
            fwd_src_e sel;

            // A load in ID/EX has no data yet; that case is a stall, not a forward.
            always_comb begin
                sel = FWD_RF;
                if (!src_nz[gi]) begin
                    sel = FWD_ZERO;
                end else if (ex_hit[gi] && !ex_is_load) begin
                    sel = FWD_EX;
                end else if (mem_hit[gi]) begin
                    sel = FWD_MEM;
                end
            end

            assign opnd[gi] = (sel == FWD_ZERO) ? '0            :
                              (sel == FWD_EX)   ? ex_alu_result :
                              (sel == FWD_MEM)  ? mem_data      :
                                                  rf_rdata[gi];
`else
            // Register file already covers register 0 and WB write-through.
            assign opnd[gi] = rf_rdata[gi];
`endif
        end
    endgenerate

`ifdef ID_FWD_EN
    assign stall = in_valid && ex_writes && ex_is_load && (out_rw_reg != '0) &&
                   ((out_rw_reg == ra_idx) || (rb_used && (out_rw_reg == rb_idx)));
`else
    // Without EX/MEM bypass any producer still in flight blocks its consumer.
    assign stall = in_valid &&
                   ((ex_hit[0] || mem_hit[0]) || (rb_used && (ex_hit[1] || mem_hit[1])));

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_alu_result, mem_data, ex_is_load};
`endif

    assign advance      = out_ready || !out_valid_reg;
    assign in_ready     = advance && !stall;
    assign hazard_stall = stall;

    // Flush outranks everything; a stalled advance pushes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_pc_reg     <= '0;
            out_imm_reg    <= '0;
            out_ra_v_reg   <= '0;
            out_rb_v_reg   <= '0;
            out_ctrl_reg   <= '0;
            out_alu_op_reg <= '0;
            out_rw_reg     <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
            out_ctrl_reg  <= CW'(CTRL_BUBBLE);
        end else if (advance) begin
            if (stall) begin
                out_valid_reg <= 1'b0;
                out_ctrl_reg  <= CW'(CTRL_BUBBLE);
            end else begin
                out_valid_reg  <= in_valid;
                out_pc_reg     <= pc_in;
                out_imm_reg    <= imm_in;
                out_ra_v_reg   <= opnd[0];
                out_rb_v_reg   <= opnd[1];
                out_ctrl_reg   <= ctrl_in;
                out_alu_op_reg <= alu_op_in;
                out_rw_reg     <= rw_idx;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_pc     = out_pc_reg;
    assign out_imm    = out_imm_reg;
    assign out_ra_v   = out_ra_v_reg;
    assign out_rb_v   = out_rb_v_reg;
    assign out_ctrl   = out_ctrl_reg;
    assign out_alu_op = out_alu_op_reg;
    assign out_rw     = out_rw_reg;

endmodule

// File: tb/tb_id_stage_fwd.sv
// -----------------------------------------------------------------------------
// tb_id_stage_fwd
// Self-checking bench for id_stage_fwd. Expectations depend on the ID_FWD_EN
// build macro (full forwarding vs. WB write-through only).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_stage_fwd;

`ifdef ID_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int AW = 5;

    localparam logic [12:0] C_ALU    = 13'h200;   // writes reg
    localparam logic [12:0] C_ALU_RR = 13'h201;   // writes reg, rB used
    localparam logic [12:0] C_LOAD   = 13'h202;   // load, writes reg
    localparam logic [12:0] C_NOWR   = 13'h001;   // no reg write, rB used

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     pc_in;
    logic [31:0]     imm_in;
    logic [12:0]     ctrl_in;
    logic [3:0]      alu_op_in;
    logic [AW-1:0]   ra_idx;
    logic [AW-1:0]   rb_idx;
    logic [AW-1:0]   rw_idx;
    logic [31:0]     ex_alu_result;
    logic            mem_we;
    logic [AW-1:0]   mem_sel;
    logic [31:0]     mem_data;
    logic            wb_we;
    logic [AW-1:0]   wb_sel;
    logic [31:0]     wb_data;
    logic            out_ready;
    logic            flush;
    logic            out_valid;
    logic [31:0]     out_pc;
    logic [31:0]     out_imm;
    logic [31:0]     out_ra_v;
    logic [31:0]     out_rb_v;
    logic [12:0]     out_ctrl;
    logic [3:0]      out_alu_op;
    logic [AW-1:0]   out_rw;
    logic            hazard_stall;

    id_stage_fwd dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pc_in         (pc_in),
        .imm_in        (imm_in),
        .ctrl_in       (ctrl_in),
        .alu_op_in     (alu_op_in),
        .ra_idx        (ra_idx),
        .rb_idx        (rb_idx),
        .rw_idx        (rw_idx),
        .ex_alu_result (ex_alu_result),
        .mem_we        (mem_we),
        .mem_sel       (mem_sel),
        .mem_data      (mem_data),
        .wb_we         (wb_we),
        .wb_sel        (wb_sel),
        .wb_data       (wb_data),
        .out_ready     (out_ready),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_imm       (out_imm),
        .out_ra_v      (out_ra_v),
        .out_rb_v      (out_rb_v),
        .out_ctrl      (out_ctrl),
        .out_alu_op    (out_alu_op),
        .out_rw        (out_rw),
        .hazard_stall  (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        valid;
        logic [12:0] ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] ra_v;
        logic [31:0] rb_v;
        logic [AW-1:0] rw;
        logic [3:0]  alu_op;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    // One record = producer loaded into ID/EX, then consumer in ID with the
    // given EX/MEM/WB traffic, then a drain cycle.
    typedef struct {
        string       name;
        logic [12:0] p_ctrl;
        logic [AW-1:0] p_rw;
        logic [12:0] c_ctrl;
        logic [AW-1:0] c_ra;
        logic [AW-1:0] c_rb;
        logic [31:0] ex_res;
        logic        m_we;
        logic [AW-1:0] m_sel;
        logic [31:0] m_data;
        logic        w_we;
        logic [AW-1:0] w_sel;
        logic [31:0] w_data;
        logic        e_stall;
        logic [31:0] e_ra;
        logic [31:0] e_rb;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input string n,
                                input logic [12:0] pc_, input logic [AW-1:0] prw,
                                input logic [12:0] cc, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                input logic [31:0] ex,
                                input logic mwe, input logic [AW-1:0] msel, input logic [31:0] md,
                                input logic wwe, input logic [AW-1:0] wsel, input logic [31:0] wd,
                                input logic st, input logic [31:0] era, input logic [31:0] erb);
        vec_t v;
        v.name = n;   v.p_ctrl = pc_; v.p_rw = prw;
        v.c_ctrl = cc; v.c_ra = ra;   v.c_rb = rb;
        v.ex_res = ex;
        v.m_we = mwe; v.m_sel = msel; v.m_data = md;
        v.w_we = wwe; v.w_sel = wsel; v.w_data = wd;
        v.e_stall = st; v.e_ra = era; v.e_rb = erb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; ctrl_in = '0; ra_idx = '0; rb_idx = '0; rw_idx = '0;
        pc_in = '0; imm_in = '0; alu_op_in = '0; ex_alu_result = '0;
        mem_we = 1'b0; mem_sel = '0; mem_data = '0;
        wb_we = 1'b0; wb_sel = '0; wb_data = '0;
        out_ready = 1'b1; flush = 1'b0;
    endtask

    task automatic drive_id(input logic [12:0] c, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [AW-1:0] w, input logic [31:0] p);
        in_valid  = 1'b1;
        ctrl_in   = c;
        ra_idx    = a;
        rb_idx    = b;
        rw_idx    = w;
        pc_in     = p;
        imm_in    = p ^ 32'hFFFF_0000;
        alu_op_in = p[5:2];
    endtask

    // Called just after a falling edge with inputs set. Checks the
    // combinational outputs, queues the expected ID/EX contents, and compares
    // them after the rising edge. Returns just after the next falling edge.
    task automatic clock_step(input string tag, input bit chk, input logic e_stall, input logic e_rdy,
                              input logic e_valid, input logic [31:0] e_ra, input logic [31:0] e_rb);
        exp_t e;
        #1;
        if (chk) begin
            check({tag, "/hazard_stall"}, 32'(hazard_stall), 32'(e_stall));
            check({tag, "/in_ready"}, 32'(in_ready), 32'(e_rdy));
            e.valid  = e_valid;
            e.ctrl   = e_valid ? ctrl_in : 13'h0;
            e.pc     = pc_in;
            e.imm    = imm_in;
            e.ra_v   = e_ra;
            e.rb_v   = e_rb;
            e.rw     = rw_idx;
            e.alu_op = alu_op_in;
            e.tag    = tag;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            e = exp_q.pop_front();
            check({e.tag, "/out_valid"}, 32'(out_valid), 32'(e.valid));
            check({e.tag, "/out_ctrl"}, 32'(out_ctrl), 32'(e.ctrl));
            if (e.valid) begin
                check({e.tag, "/out_pc"}, out_pc, e.pc);
                check({e.tag, "/out_imm"}, out_imm, e.imm);
                check({e.tag, "/out_ra_v"}, out_ra_v, e.ra_v);
                check({e.tag, "/out_rb_v"}, out_rb_v, e.rb_v);
                check({e.tag, "/out_rw"}, 32'(out_rw), 32'(e.rw));
                check({e.tag, "/out_alu_op"}, 32'(out_alu_op), 32'(e.alu_op));
            end
            $display("txn %-16s stall=%0b valid=%0b ra_v=0x%0h rb_v=0x%0h", e.tag, e_stall,
                     out_valid, out_ra_v, out_rb_v);
        end
        @(negedge clk);
    endtask

    initial begin
        // Register file after preload: r3=0x33 r4=0x44 r5=0x55 r6=0x66
        //               name            prod      prw  cons      ra rb  ex            mem           wb              stall  ra_v                 rb_v
        vecs[0]  = mk("ex_fwd",         C_ALU,    3, C_ALU,    3, 0, 32'h1234, 0,0,0,          0,0,0,          !FWD,  32'h1234, 0);
        vecs[1]  = mk("load_use_rb",    C_LOAD,   4, C_ALU_RR, 0, 4, 32'h0,    0,0,0,          0,0,0,          1'b1,  0, 0);
        vecs[2]  = mk("load_rb_unused", C_LOAD,   4, C_ALU,    0, 4, 32'hDEAD, 0,0,0,          0,0,0,          1'b0,  0, 32'h44);
        vecs[3]  = mk("prio_ex",        C_ALU,    7, C_ALU,    7, 0, 32'h1,    1,7,32'h2,      1,7,32'h3,      !FWD,  32'h1, 0);
        vecs[4]  = mk("prio_mem",       C_ALU,    8, C_ALU,    7, 0, 32'h1,    1,7,32'h2,      1,7,32'h3,      !FWD,  32'h2, 0);
        vecs[5]  = mk("prio_wb",        C_ALU,    8, C_ALU,    7, 0, 32'h1,    0,7,32'h2,      1,7,32'h3,      1'b0,  32'h3, 0);
        vecs[6]  = mk("wb_r0",          C_ALU,    0, C_ALU_RR, 0, 0, 32'h9999, 1,0,32'hEEEE,   1,0,32'hFFFF,   1'b0,  0, 0);
        vecs[7]  = mk("load_r0",        C_LOAD,   0, C_ALU_RR, 0, 0, 32'h77,   0,0,0,          0,0,0,          1'b0,  0, 0);
        vecs[8]  = mk("mem_fwd_rb",     C_ALU,    8, C_ALU_RR, 0, 5, 32'h0,    1,5,32'hAAAA,   0,0,0,          !FWD,  0, 32'hAAAA);
        vecs[9]  = mk("rf_read",        C_ALU,    8, C_ALU_RR, 5, 4, 32'h0,    0,0,0,          0,0,0,          1'b0,  32'h55, 32'h44);
        vecs[10] = mk("ex_nowrite",     C_NOWR,   3, C_ALU,    3, 0, 32'hDEAD, 0,0,0,          0,0,0,          1'b0,  32'h33, 0);
        vecs[11] = mk("load_use_ra",    C_LOAD,   6, C_ALU,    6, 0, 32'h0,    0,0,0,          0,0,0,          1'b1,  0, 0);
        vecs[12] = mk("wb_through",     C_ALU,    8, C_ALU_RR, 9, 0, 32'h0,    0,0,0,          1,9,32'h999,    1'b0,  32'h999, 0);
        vecs[13] = mk("mem_rb_unused",  C_ALU,    8, C_ALU,    0, 5, 32'h0,    1,5,32'hAAAA,   0,0,0,          1'b0,  0, FWD ? 32'hAAAA : 32'h55);

        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("reset/out_valid", 32'(out_valid), 32'h0);
        check("reset/out_ctrl", 32'(out_ctrl), 32'h0);
        check("reset/out_pc", out_pc, 32'h0);
        check("reset/out_ra_v", out_ra_v, 32'h0);
        check("reset/hazard_stall", 32'(hazard_stall), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 3; r <= 6; r++) begin
            idle_inputs();
            wb_we = 1'b1; wb_sel = AW'(r); wb_data = 32'(r) * 32'h11;
            clock_step("preload", 0, 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            drive_id(vecs[i].p_ctrl, '0, '0, vecs[i].p_rw, 32'h200 + 32'(i) * 4);
            clock_step("producer", 0, 0, 0, 0, 0, 0);

            idle_inputs();
            drive_id(vecs[i].c_ctrl, vecs[i].c_ra, vecs[i].c_rb, 5'd2, 32'h1000 + 32'(i) * 16);
            ex_alu_result = vecs[i].ex_res;
            mem_we = vecs[i].m_we; mem_sel = vecs[i].m_sel; mem_data = vecs[i].m_data;
            wb_we  = vecs[i].w_we; wb_sel  = vecs[i].w_sel; wb_data  = vecs[i].w_data;
            clock_step(vecs[i].name, 1, vecs[i].e_stall, !vecs[i].e_stall, !vecs[i].e_stall,
                       vecs[i].e_ra, vecs[i].e_rb);

            idle_inputs();
            clock_step("drain", 0, 0, 0, 0, 0, 0);
        end

        // Load-use: one stall, then the load data arrives from MEM (or WB).
        idle_inputs();
        drive_id(C_LOAD, 0, 0, 4, 32'h300);
        clock_step("lu_load", 0, 0, 0, 0, 0, 0);
        idle_inputs();
        drive_id(C_ALU_RR, 0, 4, 2, 32'h304);
        clock_step("lu_stall", 1, 1, 0, 0, 0, 0);
        idle_inputs();
        drive_id(C_ALU_RR, 0, 4, 2, 32'h304);
        mem_we = 1'b1; mem_sel = 5'd4; mem_data = 32'hBEEF;
`ifdef ID_FWD_EN
        clock_step("lu_memfwd", 1, 0, 1, 1, 0, 32'hBEEF);
`else
        clock_step("lu_memstall", 1, 1, 0, 0, 0, 0);
        idle_inputs();
        drive_id(C_ALU_RR, 0, 4, 2, 32'h304);
        wb_we = 1'b1; wb_sel = 5'd4; wb_data = 32'hBEEF;
        clock_step("lu_wbfwd", 1, 0, 1, 1, 0, 32'hBEEF);
`endif

        // Hold: EX not ready keeps the ID/EX entry.
        idle_inputs();
        drive_id(C_ALU, 0, 0, 9, 32'h500);
        clock_step("hold_load", 1, 0, 1, 1, 0, 0);
        idle_inputs();
        drive_id(C_ALU, 1, 0, 2, 32'h504);
        out_ready = 1'b0;
        #1;
        check("hold/in_ready", 32'(in_ready), 32'h0);
        check("hold/hazard_stall", 32'(hazard_stall), 32'h0);
        @(posedge clk);
        #1;
        check("hold/out_valid", 32'(out_valid), 32'h1);
        check("hold/out_pc", out_pc, 32'h500);
        check("hold/out_rw", 32'(out_rw), 32'h9);
        $display("txn %-16s valid=%0b pc=0x%0h", "hold", out_valid, out_pc);
        @(negedge clk);

        // Flush wins over a stall while EX is not ready.
        idle_inputs();
        drive_id(C_LOAD, 0, 0, 4, 32'h600);
        clock_step("flush_load", 1, 0, 1, 1, 0, 0);
        idle_inputs();
        drive_id(C_ALU_RR, 0, 4, 2, 32'h604);
        out_ready = 1'b0;
        flush = 1'b1;
        #1;
        check("flush/hazard_stall", 32'(hazard_stall), 32'h1);
        check("flush/in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        check("flush/out_valid", 32'(out_valid), 32'h0);
        check("flush/out_ctrl", 32'(out_ctrl), 32'h0);
        $display("txn %-16s valid=%0b ctrl=0x%0h", "flush", out_valid, out_ctrl);
        @(negedge clk);

        // Reset in the middle of a run with a valid entry.
        idle_inputs();
        drive_id(C_ALU, 5, 0, 3, 32'h700);
        clock_step("pre_reset", 1, 0, 1, 1, 32'h55, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst/out_valid", 32'(out_valid), 32'h0);
        check("midrst/out_ctrl", 32'(out_ctrl), 32'h0);
        check("midrst/out_pc", out_pc, 32'h0);
        check("midrst/out_ra_v", out_ra_v, 32'h0);
        check("midrst/out_rw", 32'(out_rw), 32'h0);
        $display("txn %-16s valid=%0b pc=0x%0h", "mid_reset", out_valid, out_pc);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        drive_id(C_ALU, 5, 0, 3, 32'h704);
        clock_step("rst_r5", 1, 0, 1, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_fwd.md
# id_stage_fwd

Parametrised decode-stage back end for the forwarding (redirect) pipeline. It holds the register file and the ID/EX pipeline register, and resolves RAW hazards. Operands are forwarded from EX, MEM and WB; a stall is inserted only for load-use. Decoder and controller outputs (register indices, immediate, control bundle, ALU op) feed it, and its registered outputs drive the EX stage.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, register count (power of two); AW = $clog2(NREG)
- CW, 13, control bundle width
- RWEN_BIT, 9, control bit: writes register
- MEMRD_BIT, 1, control bit: load
- RBVALID_BIT, 0, control bit: rB is a source

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID holds a valid instruction
- in_ready  out  1  ID instruction accepted this cycle
- pc_in, imm_in  in  XLEN  pc and extended immediate
- ctrl_in  in  CW  control bundle
- alu_op_in  in  4  ALU operation
- ra_idx, rb_idx, rw_idx  in  AW  source/destination indices
- ex_alu_result  in  XLEN  current EX result (for the instruction in ID/EX)
- mem_we  in  1  MEM-stage instruction writes a register
- mem_sel  in  AW  MEM destination
- mem_data  in  XLEN  MEM result (load data included)
- wb_we, wb_sel, wb_data  in  1/AW/XLEN  register write port
- out_ready  in  1  EX can accept
- flush  in  1  taken branch/jump: kill ID/EX contents
- out_valid  out  1  ID/EX entry valid
- out_pc, out_imm, out_ra_v, out_rb_v  out  XLEN  registered values
- out_ctrl  out  CW; out_alu_op  out  4; out_rw  out  AW
- hazard_stall  out  1  load-use stall this cycle

## Operation
- Register file: NREG x XLEN; written on rising edge when wb_we && wb_sel != 0; register 0 always reads 0.
- Operand select, per source s (ra, rb), first match wins:
  - s == 0: 0.
  - Match in EX: out_valid, out_ctrl[RWEN_BIT], !out_ctrl[MEMRD_BIT] and out_rw == s give ex_alu_result.
  - Match in MEM: mem_we && mem_sel == s gives mem_data.
  - Match in WB: wb_we && wb_sel == s gives wb_data (write-through).
  - Otherwise: register file.
- Load-use hazard: hazard_stall = in_valid && out_valid && out_ctrl[RWEN_BIT] && out_ctrl[MEMRD_BIT] && out_rw != 0 && (out_rw == ra_idx || (ctrl_in[RBVALID_BIT] && out_rw == rb_idx)).
- advance = out_ready || !out_valid; in_ready = advance && !hazard_stall.
- ID/EX update, priority order:
  - flush: out_valid = 0, out_ctrl = 0.
  - else if advance && hazard_stall: insert a bubble (valid 0, ctrl 0).
  - else if advance: load inputs, with out_valid = in_valid.
  - else: hold.
- Bubbles carry ctrl = 0, so no register write and no memory side effects.

## Timing
- Reset (async assert, sync to clk on release): all out_* = 0, out_valid = 0, every register = 0.
- Latency: one cycle from acceptance to out_*.
- hazard_stall, in_ready and the operand muxes are combinational in the same cycle. Any stall lasts exactly one cycle unless out_ready is low.
- Flush together with a stall or hold: flush wins. in_ready still follows the rule above, so ID must discard its own instruction on flush.
- WB write and read of the same index in the same cycle: the read returns wb_data.
- A WB write to register 0 is discarded, and register 0 is never forwarded.

## Configuration
- ID_FWD_EN defined: full forwarding as above.
- ID_FWD_EN undefined: EX/MEM forwarding paths removed; WB write-through kept. hazard_stall asserts for any in-flight match:
  - an ID/EX entry that writes, or mem_we, with destination equal to a used nonzero source.
  - A stall persists until the producer has reached WB.

## Structure
- Shared package id_pkg: XLEN/NREG defaults, control bit-position constants, and the bubble control constant (all zero).
- Sub-module id_regfile: the NREG x XLEN array with async reset, one write port, two read ports and write-through. Forwarding, hazard and ID/EX logic stay in id_stage_fwd.

## Test plan
- Reset mid-run: assert rst_n low with out_valid = 1 -> all outputs 0 immediately; register 5 reads 0 after release.
- EX forward: the ID/EX entry is an ALU op writing r3 with ex_alu_result = 0x1234; ID reads ra = 3 -> out_ra_v = 0x1234 next cycle, no stall.
- Load-use: the ID/EX entry is a load to r4; ID uses rb = 4 with RBVALID set -> hazard_stall = 1 for one cycle and a bubble enters. The next cycle takes mem_data = 0xBEEF into out_rb_v.
- Priority: EX, MEM and WB all target r7 (EX = 1, MEM = 2, WB = 3) -> 1; with EX removed -> 2; with MEM removed -> 3.
- Flush: flush = 1 while out_ready = 0 and hazard_stall = 1 -> out_valid = 0 and out_ctrl = 0 next cycle.
- Register 0: wb_we writes 0xFFFF to r0, ID reads ra = 0 in the same cycle and later -> 0. A load to r0 in ID/EX does not stall.
